// File: rtl/pixel_pkg.sv
// Shared sizing constants, FSM state type and lane-mask helper for the pixel word packer.
package pixel_pkg;

    localparam int unsigned PIX_W          = 8;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned WORD_W         = 32;
    localparam int unsigned CNT_W          = 16;
    localparam int unsigned IDX_W          = 2;

    typedef enum logic [0:0] {
        COLLECT,
        FLUSH_PEND
    } pack_state_e;

    // Mask with the lowest n lanes set; n ranges 0..BYTES_PER_WORD.
    function automatic logic [BYTES_PER_WORD-1:0] lane_mask(input logic [IDX_W:0] n);
        logic [BYTES_PER_WORD-1:0] m;
        m = '0;
        for (int k = 0; k < int'(BYTES_PER_WORD); k++) begin
            if (k < int'(n)) begin
                m[k] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/pixel_word_packer_if.sv
// Byte-in / word-out stream bundle of the pixel word packer.
interface pixel_word_packer_if;
    import pixel_pkg::*;

    logic                      valid_in;
    logic                      ready_in;
    logic [PIX_W-1:0]          data_in;
    logic                      flush;
    logic                      valid_out;
    logic                      ready_out;
    logic [WORD_W-1:0]         data_out;
    logic [BYTES_PER_WORD-1:0] keep_out;
    logic                      last_out;
    logic [CNT_W-1:0]          word_count;

    // Stimulus side: drives pixels, flush and downstream readiness.
    modport master (
        output valid_in, data_in, flush, ready_out,
        input  ready_in, valid_out, data_out, keep_out, last_out, word_count
    );

    // Packer side.
    modport slave (
        input  valid_in, data_in, flush, ready_out,
        output ready_in, valid_out, data_out, keep_out, last_out, word_count
    );

endinterface

// File: rtl/word_out_stage.sv
// Single-entry output register with valid/ready handshake and a wrapping transfer counter.
module word_out_stage
    import pixel_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [WORD_W-1:0]         load_data,
    input  logic [BYTES_PER_WORD-1:0] load_keep,
    input  logic                      load_last,
    input  logic                      ready_out,
    output logic                      can_load,
    output logic                      valid_out,
    output logic [WORD_W-1:0]         data_out,
    output logic [BYTES_PER_WORD-1:0] keep_out,
    output logic                      last_out,
    output logic [CNT_W-1:0]          word_count
);

    logic                      valid_q;
    logic [WORD_W-1:0]         data_q;
    logic [BYTES_PER_WORD-1:0] keep_q;
    logic                      last_q;
    logic [CNT_W-1:0]          count_q;
    logic                      out_xfer;

    assign out_xfer = valid_q && ready_out;
    // Free now, or freeing on this edge, so back-to-back words need no bubble.
    assign can_load = !valid_q || ready_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
            data_q  <= load_data;
            keep_q  <= load_keep;
            last_q  <= load_last;
        end else if (out_xfer) begin
            valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (out_xfer) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign valid_out  = valid_q;
    assign data_out   = data_q;
    assign keep_out   = keep_q;
    assign last_out   = last_q;
    assign word_count = count_q;

endmodule

// File: rtl/pixel_word_packer.sv
// Packs a stream of pixel bytes into 32-bit words; flush closes a partial group with last set.
module pixel_word_packer
    import pixel_pkg::*;
(
    input logic                clk,
    input logic                rst,
    pixel_word_packer_if.slave bus
);

    pack_state_e               state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [WORD_W-1:0]         asm_q, asm_d;

    logic                      can_load;
    logic                      idx_last;
    logic                      in_xfer;
    logic [IDX_W-1:0]          idx_inc;
    logic [WORD_W-1:0]         asm_merged;
    logic [BYTES_PER_WORD-1:0] keep_cur;
    logic [BYTES_PER_WORD-1:0] keep_merged;

    logic                      load;
    logic [WORD_W-1:0]         load_data;
    logic [BYTES_PER_WORD-1:0] load_keep;
    logic                      load_last;

    assign idx_last     = (idx_q == IDX_W'(BYTES_PER_WORD - 1));
    assign idx_inc      = idx_q + IDX_W'(1);
    assign bus.ready_in = (state_q == COLLECT) && (!idx_last || can_load);
    assign in_xfer      = bus.valid_in && bus.ready_in;

    // Assembly view including this cycle's byte, so a coincident flush captures it.
    always_comb begin
        asm_merged = asm_q;
        if (in_xfer) begin
            asm_merged[int'(idx_q) * PIX_W +: PIX_W] = bus.data_in;
        end
    end

    assign keep_cur    = lane_mask({1'b0, idx_q});
    assign keep_merged = in_xfer ? lane_mask({1'b0, idx_q} + 3'd1) : keep_cur;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        asm_d     = asm_q;
        load      = 1'b0;
        load_data = asm_merged;
        load_keep = keep_merged;
        load_last = 1'b0;

        unique case (state_q)
            COLLECT: begin
                if (in_xfer && idx_last) begin
                    load      = 1'b1;
                    load_last = bus.flush;
                    idx_d     = '0;
                    asm_d     = '0;
                end else if (bus.flush && (in_xfer || (idx_q != '0))) begin
                    if (can_load) begin
                        load      = 1'b1;
                        load_last = 1'b1;
                        idx_d     = '0;
                        asm_d     = '0;
                    end else begin
                        state_d = FLUSH_PEND;
                        asm_d   = asm_merged;
                        idx_d   = in_xfer ? idx_inc : idx_q;
                    end
                end else if (in_xfer) begin
                    asm_d = asm_merged;
                    idx_d = idx_inc;
                end
            end

            FLUSH_PEND: begin
                // Input is stalled here, so the held partial word is exactly asm_q.
                load_data = asm_q;
                load_keep = keep_cur;
                if (can_load) begin
                    load      = 1'b1;
                    load_last = 1'b1;
                    idx_d     = '0;
                    asm_d     = '0;
                    state_d   = COLLECT;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= COLLECT;
            idx_q   <= '0;
            asm_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            asm_q   <= asm_d;
        end
    end

    word_out_stage u_word_out_stage (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_data  (load_data),
        .load_keep  (load_keep),
        .load_last  (load_last),
        .ready_out  (bus.ready_out),
        .can_load   (can_load),
        .valid_out  (bus.valid_out),
        .data_out   (bus.data_out),
        .keep_out   (bus.keep_out),
        .last_out   (bus.last_out),
        .word_count (bus.word_count)
    );

endmodule

// File: tb/tb_pixel_word_packer.sv
// Directed bench for pixel_word_packer: packing, flush variants, backpressure and reset.
module tb_pixel_word_packer;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    pixel_word_packer_if bus ();

    pixel_word_packer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bus.valid_in = 1'b1;
        bus.data_in  = b;
        step();
        bus.valid_in = 1'b0;
    endtask

    initial begin
        n_pass        = 0;
        n_total       = 0;
        rst           = 1'b1;
        bus.valid_in  = 1'b0;
        bus.data_in   = '0;
        bus.flush     = 1'b0;
        bus.ready_out = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid_out", 32'(bus.valid_out), 32'd0);
        chk("rst_data_out", bus.data_out, 32'h0);
        chk("rst_keep_out", 32'(bus.keep_out), 32'h0);
        chk("rst_last_out", 32'(bus.last_out), 32'd0);
        chk("rst_word_count", 32'(bus.word_count), 32'd0);
        chk("rst_ready_in", 32'(bus.ready_in), 32'd1);
        rst = 1'b0;

        // Full word, no flush
        bus.ready_out = 1'b1;
        send(8'hA5); send(8'hC3); send(8'h4C); send(8'h12);
        chk("w1_valid", 32'(bus.valid_out), 32'd1);
        chk("w1_data", bus.data_out, 32'h124CC3A5);
        chk("w1_keep", 32'(bus.keep_out), 32'hF);
        chk("w1_last", 32'(bus.last_out), 32'd0);
        chk("w1_count_before", 32'(bus.word_count), 32'd0);
        step();
        chk("w1_count_after", 32'(bus.word_count), 32'd1);
        chk("w1_valid_drained", 32'(bus.valid_out), 32'd0);

        // Partial word flush
        send(8'h11); send(8'h22);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        chk("fl_valid", 32'(bus.valid_out), 32'd1);
        chk("fl_data", bus.data_out, 32'h00002211);
        chk("fl_keep", 32'(bus.keep_out), 32'h3);
        chk("fl_last", 32'(bus.last_out), 32'd1);
        step();
        chk("fl_count", 32'(bus.word_count), 32'd2);

        // Flush with nothing collected is discarded
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        step();
        chk("empty_flush_valid", 32'(bus.valid_out), 32'd0);
        chk("empty_flush_count", 32'(bus.word_count), 32'd2);

        // Backpressure: second word waits at idx=3 until the first drains
        bus.ready_out = 1'b0;
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        chk("bp_w1_data", bus.data_out, 32'h04030201);
        send(8'h05); send(8'h06); send(8'h07);
        chk("bp_ready_in_blocked", 32'(bus.ready_in), 32'd0);
        step();
        chk("bp_w1_held", bus.data_out, 32'h04030201);
        chk("bp_w1_valid_held", 32'(bus.valid_out), 32'd1);
        chk("bp_count_held", 32'(bus.word_count), 32'd2);
        bus.valid_in  = 1'b1;
        bus.data_in   = 8'h08;
        bus.ready_out = 1'b1;
        #1;
        chk("bp_ready_in_open", 32'(bus.ready_in), 32'd1);
        @(posedge clk);
        #1;
        bus.valid_in = 1'b0;
        chk("bp_w2_data", bus.data_out, 32'h08070605);
        chk("bp_w2_valid", 32'(bus.valid_out), 32'd1);
        chk("bp_count_mid", 32'(bus.word_count), 32'd3);
        step();
        chk("bp_count_end", 32'(bus.word_count), 32'd4);
        chk("bp_valid_end", 32'(bus.valid_out), 32'd0);

        // Flush coincident with the completing byte
        send(8'h44); send(8'h55); send(8'h66);
        bus.valid_in = 1'b1;
        bus.data_in  = 8'h77;
        bus.flush    = 1'b1;
        step();
        bus.valid_in = 1'b0;
        bus.flush    = 1'b0;
        chk("cf_data", bus.data_out, 32'h77665544);
        chk("cf_keep", 32'(bus.keep_out), 32'hF);
        chk("cf_last", 32'(bus.last_out), 32'd1);
        step();
        chk("cf_count", 32'(bus.word_count), 32'd5);

        // Blocked flush goes pending and stalls input
        bus.ready_out = 1'b0;
        send(8'hB1); send(8'hB2); send(8'hB3); send(8'hB4);
        send(8'hAA);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        chk("fp_ready_in", 32'(bus.ready_in), 32'd0);
        chk("fp_held_data", bus.data_out, 32'hB4B3B2B1);
        step();
        chk("fp_ready_in_still", 32'(bus.ready_in), 32'd0);
        bus.ready_out = 1'b1;
        step();
        chk("fp_data", bus.data_out, 32'h000000AA);
        chk("fp_keep", 32'(bus.keep_out), 32'h1);
        chk("fp_last", 32'(bus.last_out), 32'd1);
        chk("fp_valid", 32'(bus.valid_out), 32'd1);
        chk("fp_count_mid", 32'(bus.word_count), 32'd6);
        chk("fp_ready_in_back", 32'(bus.ready_in), 32'd1);
        step();
        chk("fp_count_end", 32'(bus.word_count), 32'd7);

        // Reset mid-word drops the partial bytes and the counter
        send(8'h99); send(8'h88);
        rst = 1'b1;
        #1;
        chk("mr_count", 32'(bus.word_count), 32'd0);
        chk("mr_valid", 32'(bus.valid_out), 32'd0);
        chk("mr_ready_in", 32'(bus.ready_in), 32'd1);
        step();
        rst = 1'b0;
        send(8'h21); send(8'h43); send(8'h65); send(8'h87);
        chk("mr_data", bus.data_out, 32'h87654321);
        chk("mr_keep", 32'(bus.keep_out), 32'hF);
        chk("mr_last", 32'(bus.last_out), 32'd0);
        chk("mr_count_before", 32'(bus.word_count), 32'd0);
        step();
        chk("mr_count_after", 32'(bus.word_count), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
